// File: rtl/duty_pkg.sv
// Shared types and constants for the duty-pattern arbiter.
package duty_pkg;

  localparam int unsigned FRAME_LEN   = 8;
  localparam int unsigned LEVEL_W     = 3;
  localparam int unsigned PHASE_W     = 3;
  localparam int unsigned FRAME_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StRelease
  } state_e;

endpackage

// File: rtl/duty_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/duty_arbiter.sv
// Round-robin sequencer granting the duty-pattern datapath for HOLD_FRAMES frames per grant.
// Optional DUTY_ABORT_EN: a dropped request ends the grant at the next frame boundary.
module duty_arbiter
  import duty_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic [NREQ-1:0]         req,
  input  logic [LEVEL_W*NREQ-1:0] level,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [LEVEL_W-1:0]      addr,
  output logic                    enable,
  output logic                    dp_clear,
  output logic [PHASE_W-1:0]      phase,
  output logic                    busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        win_q, win_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [LEVEL_W-1:0]     addr_q, addr_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;

  logic [NREQ-1:0]    pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;
  logic [LEVEL_W-1:0] level_arr [NREQ];
  logic               frame_end;
  logic               last_frame;
  logic               abort;

  for (genvar i = 0; i < NREQ; i++) begin : g_level
    assign level_arr[i] = level[LEVEL_W*i +: LEVEL_W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign frame_end  = (phase_q == PHASE_W'(FRAME_LEN - 1));
  assign last_frame = (frame_q == FRAME_CNT_W'(HOLD_FRAMES - 1));

`ifdef DUTY_ABORT_EN
  assign abort = ~req[win_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    done_d  = '0;
    addr_d  = addr_q;
    phase_d = '0;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StLoad;
          win_d   = pick_idx;
          grant_d = pick_gnt;
          addr_d  = level_arr[pick_idx];
          frame_d = '0;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        phase_d = phase_q + 1'b1;
        if (frame_end) begin
          frame_d = frame_q + 1'b1;
          // Leaving only at phase 7 keeps every frame on the output complete.
          if (last_frame || abort) begin
            state_d = StRelease;
            grant_d = '0;
            done_d  = grant_q;
            ptr_d   = (win_q == IdxW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          end
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      phase_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign addr     = addr_q;
  assign phase    = phase_q;
  assign enable   = (state_q == StRun);
  assign dp_clear = (state_q != StRun);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_duty_arbiter.sv
// Bench for duty_arbiter: offset-based grant model checked every cycle plus directed scenarios.
module tb_duty_arbiter;

  localparam int NREQ   = 4;
  localparam int H      = 2;
  localparam int RelOff = 8 * H + 1;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [3:0]  req;
  logic [11:0] level;
  logic [3:0]  grant, done;
  logic [2:0]  addr, phase;
  logic        enable, dp_clear, busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  duty_arbiter #(
    .NREQ        (NREQ),
    .HOLD_FRAMES (H)
  ) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .req      (req),
    .level    (level),
    .grant    (grant),
    .done     (done),
    .addr     (addr),
    .enable   (enable),
    .dp_clear (dp_clear),
    .phase    (phase),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: m_off is the cycle offset inside the current grant (-1 when idle).
  // Offset 0 = load, 1..8H = run, 8H+1 = release.
  int         m_off, m_win, m_ptr;
  logic [2:0] m_addr;

  always @(posedge clock or negedge clear_n) begin
    int  w;
    bit  ab;
    if (!clear_n) begin
      m_off  <= -1;
      m_ptr  <= 0;
      m_win  <= 0;
      m_addr <= '0;
    end else if (m_off < 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_win  <= w;
        m_addr <= level[3*w +: 3];
        m_off  <= 0;
      end
    end else if (m_off == RelOff) begin
      m_off <= -1;
      m_ptr <= (m_win + 1) % NREQ;
    end else begin
      ab = 1'b0;
`ifdef DUTY_ABORT_EN
      ab = (m_off >= 1) && ((m_off - 1) % 8 == 7) && !req[m_win];
`endif
      m_off <= ab ? RelOff : m_off + 1;
    end
  end

  logic [3:0] e_grant, e_done;
  logic [2:0] e_phase;
  logic       e_enable, e_busy;

  always_comb begin
    e_grant  = '0;
    e_done   = '0;
    e_phase  = '0;
    e_enable = 1'b0;
    e_busy   = (m_off >= 0);
    if (m_off >= 0 && m_off <= 8 * H) e_grant = 4'(1) << m_win;
    if (m_off == RelOff) e_done = 4'(1) << m_win;
    if (m_off >= 1 && m_off <= 8 * H) begin
      e_enable = 1'b1;
      e_phase  = 3'((m_off - 1) % 8);
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("grant",    32'(grant),    32'(e_grant));
      check("done",     32'(done),     32'(e_done));
      check("addr",     32'(addr),     32'(m_addr));
      check("enable",   32'(enable),   32'(e_enable));
      check("dp_clear", 32'(dp_clear), 32'(!e_enable));
      check("phase",    32'(phase),    32'(e_phase));
      check("busy",     32'(busy),     32'(e_busy));
    end
  end

  int         en_cnt, done_at, idle_at, zero_run, hi_run;
  logic [3:0] done_val, prev_g;
  logic [2:0] ph [16];
  bit         found;
  logic [3:0] seq[$];
  int         gaps[$];
  int         lens[$];
  logic [3:0] exp_seq [5];

  initial begin
    clear_n = 1'b0;
    req     = '0;
    level   = '0;
    repeat (3) @(negedge clock);
    check("rst_grant",    32'(grant),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_addr",     32'(addr),     32'd0);
    check("rst_enable",   32'(enable),   32'd0);
    check("rst_dp_clear", 32'(dp_clear), 32'd1);
    check("rst_phase",    32'(phase),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    cmp_en  = 1'b1;
    clear_n = 1'b1;
    repeat (4) @(negedge clock);
    check("idle_no_req", 32'(busy), 32'd0);

    // Single request from requester 0, level 2; the req drop during RUN is ignored.
    level[2:0] = 3'd2;
    req        = 4'b0001;
    @(negedge clock);
    check("single_grant",   32'(grant),    32'h1);
    check("single_addr",    32'(addr),     32'd2);
    check("load_dp_clear",  32'(dp_clear), 32'd1);
    req     = '0;
    en_cnt  = 0;
    done_at = -1;
    idle_at = -1;
    done_val = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (enable) begin
        if (en_cnt < 16) ph[en_cnt] = phase;
        en_cnt++;
      end
      if (done != 0) begin
        done_at  = k;
        done_val = done;
      end
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
    check("single_en_cycles", 32'(en_cnt),   32'd16);
    check("single_ph7",       32'(ph[7]),    32'd7);
    check("single_ph8",       32'(ph[8]),    32'd0);
    check("single_ph15",      32'(ph[15]),   32'd7);
    check("single_done_at",   32'(done_at),  32'd16);
    check("single_done_val",  32'(done_val), 32'h1);
    check("single_idle_at",   32'(idle_at),  32'd17);

    // Level change mid-grant on requester 1.
    level[5:3] = 3'd5;
    req        = 4'b0010;
    @(negedge clock);
    check("lvl_grant", 32'(grant), 32'h2);
    check("lvl_addr",  32'(addr),  32'd5);
    repeat (4) @(negedge clock);
    level[5:3] = 3'd1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done != 0) break;
    end
    check("lvl_done",      32'(done), 32'h2);
    check("lvl_addr_held", 32'(addr), 32'd5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (grant != 0) break;
    end
    check("lvl_regrant",  32'(grant), 32'h2);
    check("lvl_new_addr", 32'(addr),  32'd1);

    // Asynchronous reset at phase 4 of the running grant.
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (enable && phase == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_run_phase4", 32'(found), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    check("arst_grant",    32'(grant),    32'd0);
    check("arst_done",     32'(done),     32'd0);
    check("arst_addr",     32'(addr),     32'd0);
    check("arst_enable",   32'(enable),   32'd0);
    check("arst_dp_clear", 32'(dp_clear), 32'd1);
    check("arst_phase",    32'(phase),    32'd0);
    check("arst_busy",     32'(busy),     32'd0);
    req = '0;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    repeat (2) @(negedge clock);

    // Contention: all four requesting, pointer starts at 0 after reset.
    level    = {3'd7, 3'd6, 3'd5, 3'd4};
    req      = 4'b1111;
    prev_g   = '0;
    zero_run = 0;
    hi_run   = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clock);
      if (grant != 0 && prev_g == 0) begin
        if (seq.size() > 0) gaps.push_back(zero_run);
        seq.push_back(grant);
      end
      if (grant == 0 && prev_g != 0) lens.push_back(hi_run);
      if (grant == 0) begin
        zero_run++;
        hi_run = 0;
      end else begin
        zero_run = 0;
        hi_run++;
      end
      prev_g = grant;
      if (seq.size() == 5) break;
    end
    req = '0;
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order[%0d]", i), 32'((i < seq.size()) ? seq[i] : 4'h0),
            32'(exp_seq[i]));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_gap[%0d]", i), 32'((i < gaps.size()) ? gaps[i] : -1), 32'd2);
      check($sformatf("rr_len[%0d]", i), 32'((i < lens.size()) ? lens[i] : -1), 32'd17);
    end

    idle_at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
    check("drain_idle", 32'(idle_at >= 0), 32'd1);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
